// File: rtl/fft_frame_sched_pkg.sv
// ---------------------------------------------------------------------------
// fft_sched_pkg
// Shared definitions for the FFT frame scheduler slice:
//   NUM_REQ        number of frame requesters sharing the FFT core
//   schedState_t   scheduler FSM states (IDLE, GRANT, GAP)
//   chanId_t       channel identifier carried through the tag FIFO
//   log2Ceil       ceiling log2, used to size counters and pointers
// ---------------------------------------------------------------------------
package fft_sched_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      GAP
   } schedState_t;

   typedef logic chanId_t;

   // Smallest n such that 2**n >= value; evaluated at elaboration time.
   function automatic int log2Ceil(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fft_frame_sched_tag_fifo.sv
// ---------------------------------------------------------------------------
// fft_tag_fifo
// Small synchronous FIFO holding the channel id of every frame that has been
// handed to the FFT core but not yet fully read out.
// Ports:
//   clock, reset   clock and synchronous active-high reset
//   push, pushData write a channel id (ignored when full unless popping)
//   pop            retire the head entry (ignored when empty)
//   headData       oldest channel id (only meaningful when not empty)
//   count          current occupancy 0..DEPTH
//   empty          occupancy is zero
// ---------------------------------------------------------------------------
module fft_tag_fifo
   import fft_sched_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int COUNT_W = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               push,
   input  chanId_t            pushData,
   input  logic               pop,
   output chanId_t            headData,
   output logic [COUNT_W-1:0] count,
   output logic               empty
);

   localparam int PTR_W = (DEPTH > 1) ? log2Ceil(DEPTH) : 1;

   chanId_t          storage [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic             full;
   logic             doPush;
   logic             doPop;

   // Pointers wrap explicitly so that non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return ptr + PTR_W'(1);
   endfunction

   // Qualify push/pop against occupancy. A push into a full FIFO is still
   // accepted when the same cycle pops, because the slot being overwritten
   // is the head that is leaving.
   always_comb begin
      empty    = (count == '0);
      full     = (count == COUNT_W'(DEPTH));
      doPop    = pop && !empty;
      doPush   = push && (!full || doPop);
      headData = storage[rdPtr];
   end

   // Entry storage carries no reset; the pointers alone define validity.
   always_ff @(posedge clock) begin
      if (doPush) begin
         storage[wrPtr] <= pushData;
      end
   end

   // Pointer and occupancy bookkeeping. A simultaneous push and pop moves
   // both pointers and leaves the count unchanged.
   always_ff @(posedge clock) begin
      if (reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= advance(wrPtr);
         end
         if (doPop) begin
            rdPtr <= advance(rdPtr);
         end
         if (doPush && !doPop) begin
            count <= count + COUNT_W'(1);
         end else if (doPop && !doPush) begin
            count <= count - COUNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/fft_frame_sched.sv
// ---------------------------------------------------------------------------
// fft_frame_sched
// Shares one FFT core between two frame requesters. Whole frames of NFFT
// samples are granted round-robin when the core waits for data and fewer
// than MAX_INFLIGHT frames are outstanding; each frame's channel id is
// queued so core output can be tagged on the way to one downstream sink.
// Ports:
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_req / o_gnt               per-channel frame request / one-hot grant
//   i_data{0,1}_{i,q}           channel samples, valid while granted
//   o_fft_valid, o_fft_data_*   registered sample stream into the core
//   i_fft_wayt_data             core is ready to accept a new frame
//   i_fft_complete, i_fft_data_* core output beats
//   o_fft_ready_recive          backpressure to the core
//   o_out_*, i_out_ready        tagged downstream stream
//   o_inflight                  frames submitted but not fully read out
//   o_err                       sticky: core output with no frame queued
// ---------------------------------------------------------------------------
module fft_frame_sched
   import fft_sched_pkg::*;
#(
   parameter int SIZE_BUFFER   = 8,
   parameter int DATA_FFT_SIZE = 16,
   parameter int DATA_OUT_SIZE = 22,
   parameter int MAX_INFLIGHT  = 2
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [NUM_REQ-1:0]       i_req,
   output logic [NUM_REQ-1:0]       o_gnt,
   input  logic [DATA_FFT_SIZE-1:0] i_data0_i,
   input  logic [DATA_FFT_SIZE-1:0] i_data0_q,
   input  logic [DATA_FFT_SIZE-1:0] i_data1_i,
   input  logic [DATA_FFT_SIZE-1:0] i_data1_q,
   output logic                     o_fft_valid,
   output logic [DATA_FFT_SIZE-1:0] o_fft_data_i,
   output logic [DATA_FFT_SIZE-1:0] o_fft_data_q,
   input  logic                     i_fft_wayt_data,
   input  logic                     i_fft_complete,
   input  logic [DATA_OUT_SIZE-1:0] i_fft_data_i,
   input  logic [DATA_OUT_SIZE-1:0] i_fft_data_q,
   output logic                     o_fft_ready_recive,
   output logic                     o_out_valid,
   output logic                     o_out_last,
   output logic                     o_out_ch,
   output logic [DATA_OUT_SIZE-1:0] o_out_data_i,
   output logic [DATA_OUT_SIZE-1:0] o_out_data_q,
   input  logic                     i_out_ready,
   output logic [2:0]               o_inflight,
   output logic                     o_err
);

   localparam int NFFT  = 1 << SIZE_BUFFER;
   localparam int CNT_W = log2Ceil(NFFT);

   schedState_t      state;
   schedState_t      nextState;
   chanId_t          lastCh;
   chanId_t          winner;
   logic             startBurst;
   logic [CNT_W-1:0] sampleCnt;
   logic [CNT_W-1:0] outCnt;
   logic             tagEmpty;
   logic             outFire;
   logic             outLastBeat;
   logic             popTag;

   // Round-robin pick: lastCh remembers the last channel served, so on
   // contention the other one wins; otherwise the sole requester wins.
   always_comb begin
      if (i_req[0] && i_req[1]) begin
         winner = ~lastCh;
      end else begin
         winner = i_req[1];
      end
   end

   // Next-state and grant decode. A burst starts only from IDLE; requests
   // are not looked at during GRANT or GAP, so a requester withdrawing
   // mid-frame cannot cut the burst short. The grant follows lastCh, which
   // during GRANT is the channel currently being streamed.
   always_comb begin
      nextState  = state;
      startBurst = 1'b0;
      o_gnt      = '0;
      case (state)
         IDLE: begin
            if (i_fft_wayt_data && (o_inflight < 3'(MAX_INFLIGHT)) && (|i_req)) begin
               nextState  = GRANT;
               startBurst = 1'b1;
            end
         end
         GRANT: begin
            o_gnt[lastCh] = 1'b1;
            if (sampleCnt == CNT_W'(NFFT - 1)) begin
               nextState = GAP;
            end
         end
         GAP: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // State register, round-robin pointer and per-burst sample counter.
   // The pointer resets to channel 1 so that channel 0 is served first.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= IDLE;
         lastCh    <= 1'b1;
         sampleCnt <= '0;
      end else begin
         state <= nextState;
         if (startBurst) begin
            lastCh    <= winner;
            sampleCnt <= '0;
         end else if (state == GRANT) begin
            sampleCnt <= sampleCnt + CNT_W'(1);
         end
      end
   end

   // Registered core input: whatever the granted channel presents this
   // cycle reaches the core next cycle. Outside a burst the data is held
   // and only the valid drops.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_fft_valid  <= 1'b0;
         o_fft_data_i <= '0;
         o_fft_data_q <= '0;
      end else if (state == GRANT) begin
         o_fft_valid  <= 1'b1;
         o_fft_data_i <= lastCh ? i_data1_i : i_data0_i;
         o_fft_data_q <= lastCh ? i_data1_q : i_data0_q;
      end else begin
         o_fft_valid <= 1'b0;
      end
   end

   // Zero-latency output path. Core beats are only forwarded when a frame
   // tag exists; a stray beat with nothing queued is drained by forcing
   // ready so the core cannot stall on it.
   always_comb begin
      o_out_data_i       = i_fft_data_i;
      o_out_data_q       = i_fft_data_q;
      o_out_valid        = i_fft_complete && !tagEmpty;
      o_fft_ready_recive = i_out_ready || (i_fft_complete && tagEmpty);
      outFire            = o_out_valid && i_out_ready;
      outLastBeat        = (outCnt == CNT_W'(NFFT - 1));
      o_out_last         = o_out_valid && outLastBeat;
      popTag             = outFire && outLastBeat;
   end

   // Output beat counter (wraps on the frame's last handshake) and the
   // sticky protocol error flag.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         outCnt <= '0;
         o_err  <= 1'b0;
      end else begin
         if (outFire) begin
            outCnt <= outLastBeat ? '0 : outCnt + CNT_W'(1);
         end
         if (i_fft_complete && tagEmpty) begin
            o_err <= 1'b1;
         end
      end
   end

   fft_tag_fifo #(
      .DEPTH   (MAX_INFLIGHT),
      .COUNT_W (3)
   ) tagFifo (
      .clock    (i_clk),
      .reset    (i_reset),
      .push     (startBurst),
      .pushData (winner),
      .pop      (popTag),
      .headData (o_out_ch),
      .count    (o_inflight),
      .empty    (tagEmpty)
   );

endmodule

// File: tb/tb_fft_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_sched
// Drives the frame scheduler with directed phases and a randomized phase.
// A timeline model (burst windows, a queue of outstanding frame tags and a
// readout beat count) predicts every output each cycle; a few literal
// expectations pin the model to hand-computed numbers.
// ---------------------------------------------------------------------------
module tb_fft_frame_sched;

   localparam int NFFT = 256;
   localparam int DW   = 16;
   localparam int OW   = 22;
   localparam int MAXF = 2;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic [1:0]    i_req;
   logic [1:0]    o_gnt;
   logic [DW-1:0] i_data0_i, i_data0_q, i_data1_i, i_data1_q;
   logic          o_fft_valid;
   logic [DW-1:0] o_fft_data_i, o_fft_data_q;
   logic          i_fft_wayt_data;
   logic          i_fft_complete;
   logic [OW-1:0] i_fft_data_i, i_fft_data_q;
   logic          o_fft_ready_recive;
   logic          o_out_valid, o_out_last, o_out_ch;
   logic [OW-1:0] o_out_data_i, o_out_data_q;
   logic          i_out_ready;
   logic [2:0]    o_inflight;
   logic          o_err;

   always #5 i_clk = ~i_clk;

   fft_frame_sched #(
      .SIZE_BUFFER   (8),
      .DATA_FFT_SIZE (DW),
      .DATA_OUT_SIZE (OW),
      .MAX_INFLIGHT  (MAXF)
   ) dut (
      .i_clk              (i_clk),
      .i_reset            (i_reset),
      .i_req              (i_req),
      .o_gnt              (o_gnt),
      .i_data0_i          (i_data0_i),
      .i_data0_q          (i_data0_q),
      .i_data1_i          (i_data1_i),
      .i_data1_q          (i_data1_q),
      .o_fft_valid        (o_fft_valid),
      .o_fft_data_i       (o_fft_data_i),
      .o_fft_data_q       (o_fft_data_q),
      .i_fft_wayt_data    (i_fft_wayt_data),
      .i_fft_complete     (i_fft_complete),
      .i_fft_data_i       (i_fft_data_i),
      .i_fft_data_q       (i_fft_data_q),
      .o_fft_ready_recive (o_fft_ready_recive),
      .o_out_valid        (o_out_valid),
      .o_out_last         (o_out_last),
      .o_out_ch           (o_out_ch),
      .o_out_data_i       (o_out_data_i),
      .o_out_data_q       (o_out_data_q),
      .i_out_ready        (i_out_ready),
      .o_inflight         (o_inflight),
      .o_err              (o_err)
   );

   int total = 0;
   int bad   = 0;
   bit checkEn = 1'b0;

   // Stimulus knobs
   bit       rstReq;
   bit       reqRandom;
   bit       badComplete;
   logic [1:0] reqVal;
   int       waytMode;
   int       coreMode;
   int       readyMode;

   // Behavioural model
   int            cyc        = 0;
   int            evalFrom   = 0;
   int            burstStart = -100000;
   int            burstCh    = 0;
   int            lastServed = 1;
   int            outCount   = 0;
   int            tagQ[$];
   bit            errM       = 1'b0;
   bit            expValid   = 1'b0;
   logic [DW-1:0] expDI      = '0;
   logic [DW-1:0] expDQ      = '0;

   // Observation counters
   int   gntCycles, fftBeats, hsCount, lastCount, lastAtIdx, ch0Beats, ch1Beats;
   int   dropCyc;
   int   startQ[$];
   int   chQ[$];
   logic [1:0] prevGnt  = '0;
   logic [2:0] prevInfl = '0;

   task automatic cmp(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic clearMon();
      gntCycles = 0; fftBeats = 0; hsCount = 0; lastCount = 0; lastAtIdx = 0;
      ch0Beats = 0; ch1Beats = 0; dropCyc = 1 << 30;
      startQ.delete();
      chQ.delete();
   endtask

   task automatic applyStimulus();
      i_reset   = rstReq;
      i_req     = reqRandom ? 2'($urandom_range(0, 3)) : reqVal;
      case (waytMode)
         0:       i_fft_wayt_data = 1'b0;
         1:       i_fft_wayt_data = 1'b1;
         default: i_fft_wayt_data = 1'($urandom_range(0, 1));
      endcase
      i_data0_i = DW'($urandom);
      i_data0_q = DW'($urandom);
      i_data1_i = DW'($urandom);
      i_data1_q = DW'($urandom);
      case (coreMode)
         0:       i_fft_complete = 1'b0;
         1:       i_fft_complete = (tagQ.size() > 0);
         default: i_fft_complete = (tagQ.size() > 0) && ($urandom_range(0, 3) != 0);
      endcase
      if (badComplete) i_fft_complete = 1'b1;
      i_fft_data_i = OW'($urandom);
      i_fft_data_q = OW'($urandom);
      case (readyMode)
         0:       i_out_ready = 1'b1;
         1:       i_out_ready = ((cyc % 2) == 0);
         2:       i_out_ready = 1'($urandom_range(0, 1));
         default: i_out_ready = 1'b0;
      endcase
   endtask

   // Compare every output against the model for the current cycle, then
   // update the observation counters used by the directed checks.
   task automatic checkOutput();
      bit inWin;
      int expGnt;
      bit expOv;
      inWin  = (cyc >= burstStart) && (cyc < burstStart + NFFT);
      expGnt = inWin ? ((burstCh == 1) ? 2 : 1) : 0;
      expOv  = i_fft_complete && (tagQ.size() > 0);
      if (checkEn) begin
         cmp("gnt", int'(o_gnt), expGnt);
         cmp("fft_valid", int'(o_fft_valid), int'(expValid));
         cmp("fft_data_i", int'(o_fft_data_i), int'(expDI));
         cmp("fft_data_q", int'(o_fft_data_q), int'(expDQ));
         cmp("inflight", int'(o_inflight), tagQ.size());
         cmp("out_valid", int'(o_out_valid), int'(expOv));
         cmp("ready_recive", int'(o_fft_ready_recive),
             int'(i_out_ready || (i_fft_complete && tagQ.size() == 0)));
         cmp("err", int'(o_err), int'(errM));
         cmp("out_data_i", int'(o_out_data_i), int'(i_fft_data_i));
         cmp("out_data_q", int'(o_out_data_q), int'(i_fft_data_q));
         if (expOv) begin
            cmp("out_ch", int'(o_out_ch), tagQ[0]);
            cmp("out_last", int'(o_out_last), int'(outCount == NFFT - 1));
         end
      end
      if (o_gnt != 2'b00) gntCycles++;
      if (o_gnt != 2'b00 && prevGnt == 2'b00) begin
         startQ.push_back(cyc);
         chQ.push_back(int'(o_gnt[1]));
      end
      if (o_fft_valid) fftBeats++;
      if (o_out_valid && i_out_ready) begin
         hsCount++;
         if (o_out_last) begin
            lastCount++;
            lastAtIdx = hsCount;
         end
         if (o_out_ch) ch1Beats++;
         else ch0Beats++;
      end
      if (o_inflight < prevInfl && dropCyc < 0) dropCyc = cyc;
      prevGnt  = o_gnt;
      prevInfl = o_inflight;
   endtask

   // Advance the model across the coming clock edge using current inputs.
   // A grant decided in cycle c occupies cycles c+1..c+NFFT, its samples
   // reach the core one cycle later, and the next decision is possible in
   // cycle c+NFFT+2.
   task automatic modelStep();
      bit hs, popNow, pushNow;
      int win;
      if (i_reset) begin
         evalFrom   = cyc + 1;
         burstStart = -100000;
         lastServed = 1;
         outCount   = 0;
         tagQ.delete();
         errM       = 1'b0;
         expValid   = 1'b0;
         expDI      = '0;
         expDQ      = '0;
         cyc++;
         return;
      end
      if ((cyc >= burstStart) && (cyc < burstStart + NFFT)) begin
         expValid = 1'b1;
         expDI    = (burstCh == 1) ? i_data1_i : i_data0_i;
         expDQ    = (burstCh == 1) ? i_data1_q : i_data0_q;
      end else begin
         expValid = 1'b0;
      end
      hs = i_fft_complete && (tagQ.size() > 0) && i_out_ready;
      if (i_fft_complete && tagQ.size() == 0) errM = 1'b1;
      popNow = hs && (outCount == NFFT - 1);
      if (hs) outCount = popNow ? 0 : outCount + 1;
      pushNow = 1'b0;
      win     = 0;
      if (cyc >= evalFrom && i_fft_wayt_data && tagQ.size() < MAXF && i_req != 2'b00) begin
         if (i_req == 2'b11) win = 1 - lastServed;
         else win = i_req[1] ? 1 : 0;
         lastServed = win;
         burstCh    = win;
         burstStart = cyc + 1;
         evalFrom   = cyc + NFFT + 2;
         pushNow    = 1'b1;
      end
      if (popNow) void'(tagQ.pop_front());
      if (pushNow) tagQ.push_back(win);
      cyc++;
   endtask

   task automatic tick();
      applyStimulus();
      @(negedge i_clk);
      checkOutput();
      modelStep();
      @(posedge i_clk);
      #1;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic runUntilBursts(input int target, input int bound);
      int n;
      n = 0;
      while (startQ.size() < target && n < bound) begin
         tick();
         n++;
      end
      cmp("wait_bursts", startQ.size(), target);
   endtask

   task automatic runUntilDrained(input int bound);
      int n;
      n = 0;
      while (o_inflight != 3'd0 && n < bound) begin
         tick();
         n++;
      end
      cmp("wait_drain", int'(o_inflight), 0);
   endtask

   initial begin
      rstReq = 1'b1; reqRandom = 1'b0; badComplete = 1'b0; reqVal = 2'b00;
      waytMode = 0; coreMode = 0; readyMode = 0;
      clearMon();
      repeat (3) tick();
      rstReq  = 1'b0;
      checkEn = 1'b1;

      // Reset state
      cmp("rst_gnt", int'(o_gnt), 0);
      cmp("rst_fft_valid", int'(o_fft_valid), 0);
      cmp("rst_fft_data_i", int'(o_fft_data_i), 0);
      cmp("rst_inflight", int'(o_inflight), 0);
      cmp("rst_err", int'(o_err), 0);

      // Single frame from channel 0, then read it back
      clearMon();
      waytMode = 1;
      reqVal   = 2'b01;
      tick();
      reqVal = 2'b00;
      runCycles(300);
      cmp("single_gnt_cycles", gntCycles, 256);
      cmp("single_bursts", startQ.size(), 1);
      cmp("single_ch", (chQ.size() > 0) ? chQ[0] : 9, 0);
      cmp("single_fft_beats", fftBeats, 256);
      cmp("single_inflight", int'(o_inflight), 1);
      coreMode  = 1;
      readyMode = 0;
      runUntilDrained(2000);
      cmp("single_handshakes", hsCount, 256);
      cmp("single_last_count", lastCount, 1);
      cmp("single_last_at", lastAtIdx, 256);
      cmp("single_ch0_beats", ch0Beats, 256);

      // Contention: both request continuously
      clearMon();
      reqVal = 2'b11;
      runUntilBursts(5, 2000);
      reqVal = 2'b00;
      cmp("contention_first_ch", (chQ.size() > 0) ? chQ[0] : 9, 1);
      for (int i = 1; i < startQ.size(); i++) begin
         cmp("contention_spacing", startQ[i] - startQ[i-1], 258);
         cmp("contention_alternate", chQ[i], 1 - chQ[i-1]);
      end
      runUntilDrained(2000);

      // In-flight limit: core never answers, then frame 0 is read out
      rstReq = 1'b1;
      tick();
      rstReq = 1'b0;
      clearMon();
      coreMode = 0;
      reqVal   = 2'b11;
      runCycles(900);
      cmp("limit_bursts", startQ.size(), 2);
      cmp("limit_first_ch", (chQ.size() > 0) ? chQ[0] : 9, 0);
      cmp("limit_inflight", int'(o_inflight), 2);
      cmp("limit_gnt_blocked", int'(o_gnt), 0);
      dropCyc  = -1;
      coreMode = 1;
      runUntilBursts(3, 1000);
      cmp("limit_regrant_delay", (startQ.size() > 2) ? startQ[2] - dropCyc : -1, 1);
      reqVal = 2'b00;
      runUntilDrained(3000);

      // Backpressure: ready toggles every cycle during readout
      rstReq = 1'b1;
      tick();
      rstReq = 1'b0;
      clearMon();
      coreMode  = 1;
      readyMode = 1;
      reqVal    = 2'b01;
      tick();
      reqVal = 2'b00;
      runCycles(5);
      runUntilDrained(3000);
      cmp("bp_handshakes", hsCount, 256);
      cmp("bp_last_count", lastCount, 1);
      cmp("bp_last_at", lastAtIdx, 256);

      // Reset in the 100th cycle of a burst
      clearMon();
      readyMode = 0;
      coreMode  = 0;
      reqVal    = 2'b11;
      runUntilBursts(1, 20);
      runCycles(98);
      rstReq = 1'b1;
      tick();
      rstReq = 1'b0;
      cmp("abort_gnt", int'(o_gnt), 0);
      cmp("abort_fft_valid", int'(o_fft_valid), 0);
      cmp("abort_inflight", int'(o_inflight), 0);
      clearMon();
      runUntilBursts(1, 20);
      cmp("abort_first_ch", (chQ.size() > 0) ? chQ[0] : 9, 0);

      // Randomized traffic
      reqRandom = 1'b1;
      waytMode  = 2;
      coreMode  = 2;
      readyMode = 2;
      runCycles(4000);
      reqRandom = 1'b0;
      reqVal    = 2'b00;
      coreMode  = 1;
      readyMode = 0;
      runUntilDrained(4000);

      // Core output with nothing queued
      readyMode   = 3;
      badComplete = 1'b1;
      tick();
      cmp("err_set", int'(o_err), 1);
      cmp("err_out_valid", int'(o_out_valid), 0);
      cmp("err_ready_forced", int'(o_fft_ready_recive), 1);
      badComplete = 1'b0;
      coreMode    = 0;
      runCycles(10);
      cmp("err_sticky", int'(o_err), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_frame_sched.md
# fft_frame_sched

Frame scheduler placed in front of `myFFT_R4`, sharing one FFT core between two frame-based sample requesters. It grants whole NFFT-sample frames round-robin when the core is ready and the in-flight limit allows. It streams each frame contiguously into the core and tags every output frame with the originating channel. It also forwards core output to a single downstream consumer with ready backpressure.

## Interface
- `SIZE_BUFFER`, 8: log2 of frame length; NFFT = 2**SIZE_BUFFER.
- `DATA_FFT_SIZE`, 16: input sample width, per I/Q.
- `DATA_OUT_SIZE`, 22: FFT output width, DATA_FFT_SIZE+SIZE_BUFFER-2.
- `MAX_INFLIGHT`, 2: max frames submitted to the core but not fully read out (1..4).
- `i_clk` in 1: single clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_req` in 2: channel n holds a complete frame and can supply one sample per cycle while granted.
- `o_gnt` in→out 2: one-hot; high for exactly NFFT cycles; channel presents one sample in each such cycle.
- `i_data0_i`, `i_data0_q`, `i_data1_i`, `i_data1_q` in DATA_FFT_SIZE: channel samples.
- `o_fft_valid` out 1 / `o_fft_data_i`, `o_fft_data_q` out DATA_FFT_SIZE: to core `i_valid`/`i_data_in_*`.
- `i_fft_wayt_data` in 1: core `o_flag_wayt_data`.
- `i_fft_complete` in 1 / `i_fft_data_i`, `i_fft_data_q` in DATA_OUT_SIZE: core output.
- `o_fft_ready_recive` out 1: to core `i_flag_ready_recive`.
- `o_out_valid`, `o_out_last` out 1 / `o_out_ch` out 1 / `o_out_data_i`, `o_out_data_q` out DATA_OUT_SIZE: downstream.
- `i_out_ready` in 1: downstream ready.
- `o_inflight` out 3: tag FIFO occupancy.
- `o_err` out 1: sticky protocol error.

## Operation
- FSM states:
  - IDLE → GRANT when `i_fft_wayt_data` = 1, `o_inflight` < MAX_INFLIGHT, and `|i_req`.
  - GRANT → GAP after NFFT cycles.
  - GAP → IDLE after one cycle.
- Arbitration is round-robin. The pointer names the last-served channel, and the other channel wins when both request. Pointer resets to 1, so channel 0 wins first.
- On GRANT entry, the winning channel id is pushed into the tag FIFO (depth MAX_INFLIGHT) and a sample counter is cleared.
- `i_req` is ignored during GRANT/GAP. A requester dropping `i_req` mid-burst does not shorten the burst.
- Input path is registered: the sample present while `o_gnt[n]` = 1 appears on `o_fft_data_*` with `o_fft_valid` = 1 one cycle later. `o_fft_valid` = 0 otherwise, and `o_fft_data_*` is held.
- Output path is combinational pass-through:
  - `o_out_data_*` = `i_fft_data_*`.
  - `o_out_valid` = `i_fft_complete` & tag FIFO non-empty.
  - `o_fft_ready_recive` = `i_out_ready`.
  - `o_out_ch` = tag FIFO head.
- The output counter increments on `o_out_valid` & `i_out_ready`. `o_out_last` = 1 when count = NFFT-1. That beat pops the tag and wraps the counter to 0.
- If push and pop occur in the same cycle, occupancy is unchanged.
- If `i_fft_complete` = 1 while the tag FIFO is empty:
  - `o_err` sets and stays set until reset.
  - `o_out_valid` stays 0.
  - `o_fft_ready_recive` is forced 1 to drain.
- Reset values: FSM IDLE; `o_gnt` 0; `o_fft_valid` 0; `o_fft_data_*` 0; FIFO empty; counters 0; `o_err` 0.
- Reset mid-burst aborts the frame at the next edge. The core shares `i_reset` at top level, so no partial frame survives.

## Timing
- Grant latency: the condition is sampled in IDLE at edge k; `o_gnt` is high for cycles k+1 … k+NFFT.
- Core-input latency: `o_fft_valid` is high for cycles k+2 … k+NFFT+1.
- Minimum spacing between bursts: NFFT+2 cycles (GRANT + GAP + IDLE evaluation).
- `o_inflight` increments in cycle k+1 and decrements in the cycle after the `o_out_last` handshake.
- Output adds zero cycles of latency; backpressure propagates combinationally to the core.

## Structure
- Package `fft_sched_pkg` holds:
  - NUM_REQ = 2.
  - FSM state enum (IDLE, GRANT, GAP).
  - Channel-id type.
  - Log2 helper used for counter widths.
- Sub-module `fft_tag_fifo`: synchronous FIFO with parameterised depth, 1-bit entries, push/pop/count, and same-cycle push+pop supported.
- Arbiter, FSM, input register and output counter stay in the top module.

## Test plan
- **Single frame:** `i_req` = 01, wayt = 1 → `o_gnt` = 01 for 256 cycles, 256 `o_fft_valid` beats, `o_inflight` = 1. The core returns 256 beats → `o_out_ch` = 0, `o_out_last` on beat 255, `o_inflight` returns to 0.
- **Contention:** `i_req` = 11 held → grants alternate 0,1,0,1; each burst is 256 cycles with 258-cycle spacing.
- **In-flight limit:** no core output, MAX_INFLIGHT = 2 → two grants, then `o_gnt` stays 0 despite `i_req`. Complete frame 0 → third grant follows within 1 cycle of the pop.
- **Backpressure:** toggle `i_out_ready` 1/0 each cycle during readout → 256 handshakes, `o_out_last` on the 256th only, no data lost.
- **Error:** `i_fft_complete` = 1 with FIFO empty → `o_err` = 1 persists, `o_out_valid` = 0, `o_fft_ready_recive` = 1.
- **Reset at burst cycle 100:** next cycle `o_gnt` = 0, `o_fft_valid` = 0, `o_inflight` = 0. First grant after reset goes to channel 0.
